// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the CPU instruction/data ports, the arbiter and the SRAM macro.
// The slave modport is the arbiter's view; master is the view of the requesters and SRAM.
interface sram_port_arbiter_if #(
    parameter int unsigned SRAM_ADDR_W = 13,
    parameter int unsigned DATA_W      = 32
);
    logic                   i_valid;
    logic [SRAM_ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0]      i_rdata;
    logic                   i_ready;

    logic                   d_valid;
    logic [SRAM_ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0]      d_wdata;
    logic [DATA_W/8-1:0]    d_wstrb;
    logic [DATA_W-1:0]      d_rdata;
    logic                   d_ready;

    logic                   m_en;
    logic [DATA_W/8-1:0]    m_we;
    logic [SRAM_ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0]      m_wdata;
    logic [DATA_W-1:0]      m_rdata;

    modport slave (
        input  i_valid, i_addr,
        output i_rdata, i_ready,
        input  d_valid, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_ready,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output i_valid, i_addr,
        input  i_rdata, i_ready,
        output d_valid, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_ready,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between the instruction (read-only) and
// data (read/write) buses with round-robin arbitration and back-to-back alternation.
module sram_port_arbiter #(
    parameter int unsigned SRAM_ADDR_W = 13,
    parameter int unsigned DATA_W      = 32
) (
    input logic                clk,
    input logic                rst,
    sram_port_arbiter_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic {StIdle, StBusy} state_t;
    typedef enum logic {ReqI, ReqD} req_t;

    state_t state;
    req_t   gnt;
    req_t   last;
    req_t   winner;
    logic   i_ready_q;
    logic   d_ready_q;

    logic   i_elig;
    logic   d_elig;
    logic   issue;
    logic   i_done;
    logic   d_done;

    logic                   m_en;
    logic [STRB_W-1:0]      m_we;
    logic [SRAM_ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0]      m_wdata;

    // The in-flight requester still holds valid for the transaction completing this cycle,
    // so it must not be reissued.
    always_comb begin
        i_elig = bus.i_valid && !(state == StBusy && gnt == ReqI);
        d_elig = bus.d_valid && !(state == StBusy && gnt == ReqD);
        issue  = (i_elig || d_elig) && !rst;
        if (i_elig && d_elig) begin
            winner = (last == ReqI) ? ReqD : ReqI;
        end else if (d_elig) begin
            winner = ReqD;
        end else begin
            winner = ReqI;
        end
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (issue) begin
            m_en = 1'b1;
            if (winner == ReqD) begin
                m_addr  = bus.d_addr;
                m_we    = bus.d_wstrb;
                m_wdata = bus.d_wdata;
            end else begin
                m_addr = bus.i_addr;
            end
        end
    end

    assign bus.m_en    = m_en;
    assign bus.m_we    = m_we;
    assign bus.m_addr  = m_addr;
    assign bus.m_wdata = m_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            gnt       <= ReqI;
            last      <= ReqI;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else if (issue) begin
            state     <= StBusy;
            gnt       <= winner;
            last      <= winner;
            i_ready_q <= (winner == ReqI);
            d_ready_q <= (winner == ReqD);
        end else begin
            state     <= StIdle;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end
    end

    // Reset discards the completing access in the same cycle it is asserted.
    assign i_done = i_ready_q && !rst;
    assign d_done = d_ready_q && !rst;

    assign bus.i_ready = i_done;
    assign bus.d_ready = d_done;
    assign bus.i_rdata = i_done ? bus.m_rdata : '0;
    assign bus.d_rdata = d_done ? bus.m_rdata : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table plus randomized traffic checked
// against a transaction-level model with a shadow memory.
module tb_sram_port_arbiter;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst;
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    sram_port_arbiter_if #(.SRAM_ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_port_arbiter #(.SRAM_ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: read-first, 1-cycle read latency, byte writes.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdq;
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.m_en) begin
            rdq <= mem[bus.m_addr];
            for (int b = 0; b < 4; b++) begin
                if (bus.m_we[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
            end
        end
    end
    assign bus.m_rdata = rdq;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          iv;
        logic [AW-1:0] ia;
        logic          dv;
        logic [AW-1:0] da;
        logic [31:0]   dwd;
        logic [3:0]    dws;
        logic          men;
        logic [AW-1:0] ma;
        logic [3:0]    mwe;
        logic [31:0]   mwd;
        logic          ir;
        logic          dr;
        logic [31:0]   ird;
        logic [31:0]   drd;
    } vec_t;

    function automatic vec_t mk(input int unsigned r, iv, ia, dv, da, dwd, dws,
                                input int unsigned men, ma, mwe, mwd, ir, dr, ird, drd);
        vec_t v;
        v.rst = r[0];     v.iv = iv[0];      v.ia = AW'(ia);
        v.dv = dv[0];     v.da = AW'(da);    v.dwd = dwd;     v.dws = 4'(dws);
        v.men = men[0];   v.ma = AW'(ma);    v.mwe = 4'(mwe); v.mwd = mwd;
        v.ir = ir[0];     v.dr = dr[0];      v.ird = ird;     v.drd = drd;
        return v;
    endfunction

    task automatic apply_row(input vec_t v, input int idx);
        @(posedge clk); #1;
        rst = v.rst;
        bus.i_valid = v.iv;  bus.i_addr = v.ia;
        bus.d_valid = v.dv;  bus.d_addr = v.da;  bus.d_wdata = v.dwd;  bus.d_wstrb = v.dws;
        @(negedge clk);
        check($sformatf("row%0d m_bus", idx),
              64'({bus.m_en, bus.m_addr, bus.m_we, bus.m_wdata}),
              64'({v.men, v.ma, v.mwe, v.mwd}));
        check($sformatf("row%0d i_ready", idx), 64'(bus.i_ready), 64'(v.ir));
        check($sformatf("row%0d d_ready", idx), 64'(bus.d_ready), 64'(v.dr));
        check($sformatf("row%0d i_rdata", idx), 64'(bus.i_rdata), 64'(v.ird));
        check($sformatf("row%0d d_rdata", idx), 64'(bus.d_rdata), 64'(v.drd));
    endtask

    // Transaction-level reference: accesses issued one cycle complete the next.
    typedef struct {
        int            port;  // 0 = I, 1 = D
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   data;
    } acc_t;

    acc_t          inflight[$];
    int            last_port;
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic          i_seen, d_seen;
    int            i_wait, d_wait;
    int            n_ir, n_dr, n_men, last_ir_cyc, bad_gap;

    task automatic model_step();
        acc_t c;
        acc_t n;
        logic have = 1'b0;
        logic comp_i, comp_d, ie, de;
        int win = -1;
        logic [49:0] exp_m = '0;
        if (inflight.size() != 0) begin
            c = inflight.pop_front();
            have = 1'b1;
        end
        comp_i = have && c.port == 0;
        comp_d = have && c.port == 1;
        ie = bus.i_valid && !comp_i;
        de = bus.d_valid && !comp_d;
        if (ie && de) win = (last_port == 0) ? 1 : 0;
        else if (de) win = 1;
        else if (ie) win = 0;
        if (win == 0) exp_m = {1'b1, bus.i_addr, 4'b0, 32'b0};
        if (win == 1) exp_m = {1'b1, bus.d_addr, bus.d_wstrb, bus.d_wdata};
        check("rand m_bus", 64'({bus.m_en, bus.m_addr, bus.m_we, bus.m_wdata}), 64'(exp_m));
        check("rand i_ready", 64'(bus.i_ready), 64'(comp_i));
        check("rand d_ready", 64'(bus.d_ready), 64'(comp_d));
        check("rand i_rdata", 64'(bus.i_rdata), 64'(comp_i ? c.data : 32'b0));
        if (!(comp_d && c.wr)) begin
            check("rand d_rdata", 64'(bus.d_rdata), 64'(comp_d ? c.data : 32'b0));
        end
        if (win >= 0) begin
            n.port = win;
            n.addr = (win == 1) ? bus.d_addr : bus.i_addr;
            n.data = shadow[n.addr];
            n.wr   = (win == 1) && (bus.d_wstrb != 4'b0);
            if (n.wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.d_wstrb[b]) shadow[n.addr][8*b +: 8] = bus.d_wdata[8*b +: 8];
                end
            end
            inflight.push_back(n);
            last_port = win;
        end
    endtask

    task automatic reset_all();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int a = 0; a < (1 << AW); a++) shadow[a] = mem[a];
        inflight.delete();
        last_port = 0;
        i_seen = 1'b0;  d_seen = 1'b0;
        i_wait = 0;     d_wait = 0;
        n_ir = 0;  n_dr = 0;  n_men = 0;  last_ir_cyc = -1;  bad_gap = 0;
    endtask

    task automatic run_phase(input int ncyc, input int ip, input int dp);
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk); #1;
            if (i_seen) begin bus.i_valid = 1'b0; i_seen = 1'b0; end
            if (d_seen) begin bus.d_valid = 1'b0; d_seen = 1'b0; end
            if (!bus.i_valid && int'($urandom_range(0, 99)) < ip) begin
                bus.i_valid = 1'b1;
                bus.i_addr  = AW'($urandom_range(0, 31));
                i_wait = 0;
            end
            if (!bus.d_valid && int'($urandom_range(0, 99)) < dp) begin
                bus.d_valid = 1'b1;
                bus.d_addr  = AW'($urandom_range(0, 31));
                bus.d_wdata = $urandom;
                bus.d_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'b0;
                d_wait = 0;
            end
            @(negedge clk);
            model_step();
            if (bus.m_en) n_men++;
            if (bus.i_valid) i_wait++;
            if (bus.d_valid) d_wait++;
            if (bus.i_ready) begin
                i_seen = 1'b1;
                n_ir++;
                if (last_ir_cyc >= 0 && cyc - last_ir_cyc != 2) bad_gap++;
                last_ir_cyc = cyc;
                check("i wait bound", 64'(i_wait <= 3), 64'(1));
            end
            if (bus.d_ready) begin
                d_seen = 1'b1;
                n_dr++;
                check("d wait bound", 64'(d_wait <= 3), 64'(1));
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        pl_en = 1'b0;  pl_addr = '0;  pl_data = '0;
        bus.i_valid = 1'b0;  bus.i_addr = '0;
        bus.d_valid = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;  bus.d_wstrb = '0;

        //          rst iv ia    dv da    dwd          dws  men ma   mwe mwd  ir dr ird  drd
        tbl.push_back(mk(0, 0, 0,    0, 0,    0,           0,   0, 0,    0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h10, 0, 0,    0,           0,   1, 'h10, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h10, 0, 0,    0,           0,   0, 0,    0, 0,   1, 0,
                         'hDEADBEEF, 0));
        tbl.push_back(mk(0, 0, 0,    1, 'h20, 'h12345678, 'b0011,
                         1, 'h20, 'b0011, 'h12345678, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    1, 'h20, 'h12345678, 'b0011,
                         0, 0, 0, 0, 0, 1, 0, 'hAAAAAAAA));
        tbl.push_back(mk(0, 0, 0,    0, 0,    0,           0,   0, 0,    0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    1, 'h20, 0,           0,   1, 'h20, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    1, 'h20, 0,           0,   0, 0,    0, 0,   0, 1, 0,
                         'hAAAA5678));
        // tie with last=D: I wins, then D follows back-to-back
        tbl.push_back(mk(0, 1, 1,    1, 2,    0,           0,   1, 1,    0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,    1, 2,    0,           0,   1, 2,    0, 0,   1, 0,
                         'h11111111, 0));
        tbl.push_back(mk(0, 0, 0,    1, 2,    0,           0,   0, 0,    0, 0,   0, 1, 0,
                         'h22222222));
        // reset, then first tie goes to D
        tbl.push_back(mk(1, 1, 1,    1, 2,    0,           0,   0, 0,    0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,    1, 2,    0,           0,   1, 2,    0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,    1, 2,    0,           0,   1, 1,    0, 0,   0, 1, 0,
                         'h22222222));
        tbl.push_back(mk(0, 1, 1,    0, 0,    0,           0,   0, 0,    0, 0,   1, 0,
                         'h11111111, 0));
        // reset during a BUSY cycle discards the completion
        tbl.push_back(mk(0, 1, 'h10, 0, 0,    0,           0,   1, 'h10, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 'h10, 1, 2,    0,           0,   0, 0,    0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,    0, 0,    0,           0,   0, 0,    0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,    1, 2,    0,           0,   1, 2,    0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1,    1, 2,    0,           0,   1, 1,    0, 0,   0, 1, 0,
                         'h22222222));
        tbl.push_back(mk(0, 1, 1,    0, 0,    0,           0,   0, 0,    0, 0,   1, 0,
                         'h11111111, 0));

        // Preload the SRAM while reset is held.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            pl_en = 1'b1;
            case (k)
                0: begin pl_addr = AW'('h10); pl_data = 32'hDEADBEEF; end
                1: begin pl_addr = AW'('h20); pl_data = 32'hAAAAAAAA; end
                2: begin pl_addr = AW'(1);    pl_data = 32'h11111111; end
                default: begin pl_addr = AW'(2); pl_data = 32'h22222222; end
            endcase
        end
        @(posedge clk); #1;
        pl_en = 1'b0;
        @(negedge clk);
        check("reset i_ready", 64'(bus.i_ready), 64'(0));
        check("reset d_ready", 64'(bus.d_ready), 64'(0));
        check("reset m_en/m_we", 64'({bus.m_en, bus.m_we}), 64'(0));
        check("reset rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'(0));

        for (int r = 0; r < tbl.size(); r++) apply_row(tbl[r], r);

        // Continuous contention: SRAM busy every cycle, D/I alternate starting with D.
        reset_all();
        run_phase(20, 100, 100);
        check("contention m_en cycles", 64'(n_men), 64'(20));
        check("contention d_ready count", 64'(n_dr), 64'(10));
        check("contention i_ready count", 64'(n_ir), 64'(9));

        // Lone I requester streaming: one ready every 2 cycles.
        reset_all();
        run_phase(16, 100, 0);
        check("lone i_ready count", 64'(n_ir), 64'(8));
        check("lone i_ready spacing", 64'(bad_gap), 64'(0));
        check("lone m_en cycles", 64'(n_men), 64'(8));

        reset_all();
        run_phase(400, 40, 40);
        run_phase(300, 90, 90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
